// File: rtl/game_pkg.sv
// Shared types and default constants for the whack-a-mole game controller.
// State encoding plus default sizing used by game_control_fsm and its bench.
package game_pkg;

  localparam int DEF_SCORE_W    = 12;
  localparam int DEF_WIN_SCORE  = 1000;
  localparam int DEF_MAX_LIVES  = 3;
  localparam int DEF_LEVEL_STEP = 250;
  localparam int DEF_NUM_LEVELS = 4;
  localparam int DEF_ROUND_MS   = 60000;
  localparam int DEF_TIMER_W    = 16;

  typedef enum logic [2:0] {
    SETUP     = 3'd0,
    WAIT      = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    GAME_OVER = 3'd4,
    WIN       = 3'd5
  } game_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for a level button: rise is combinational, one cycle per 0->1.
// Reset clears the history so a button held through reset reads as a fresh press.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
    rise   = din & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/game_control_fsm.sv
// Game sequencing FSM: setup/countdown/play/pause/end states, lives, level and round timer.
// Flags decode state combinationally; new_mole is registered one cycle. GAME_PAUSE_EN enables pause.
module game_control_fsm
  import game_pkg::*;
#(
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int WIN_SCORE  = DEF_WIN_SCORE,
  parameter int MAX_LIVES  = DEF_MAX_LIVES,
  parameter int LEVEL_STEP = DEF_LEVEL_STEP,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int ROUND_MS   = DEF_ROUND_MS,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic                            pause,
  input  logic                            countdown_complete,
  input  logic                            mole_complete,
  input  logic                            mole_missed,
  input  logic                            ms_tick,
  input  logic [SCORE_W-1:0]              score,
  output logic                            timer_reset,
  output logic                            wait_flag,
  output logic                            play_flag,
  output logic                            pause_flag,
  output logic                            gameover_flag,
  output logic                            win_flag,
  output logic                            new_mole,
  output logic [$clog2(MAX_LIVES+1)-1:0]  lives,
  output logic [$clog2(NUM_LEVELS)-1:0]   level,
  output logic [TIMER_W-1:0]              time_left_ms
);

  localparam int LIVES_W = $clog2(MAX_LIVES + 1);
  localparam int LEVEL_W = $clog2(NUM_LEVELS);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [TIMER_W-1:0] TIME_INIT  = TIMER_W'(ROUND_MS);
  localparam logic [31:0]        WIN_U      = 32'(WIN_SCORE);
  localparam logic [31:0]        STEP_U     = 32'(LEVEL_STEP);

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  game_state_t        state_q, state_d;
  logic               new_mole_q, new_mole_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TIMER_W-1:0] time_q, time_d;

  logic        play_rise;
  logic        pause_rise_raw;
  logic        pause_rise;
  logic [31:0] score_u;
  logic [31:0] level_thresh;
  logic        win_hit;
  logic        lose_hit;

  rise_edge_detect u_play_edge (
    .clk   (clk),
    .reset (reset),
    .din   (play),
    .rise  (play_rise)
  );

  rise_edge_detect u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .din   (pause),
    .rise  (pause_rise_raw)
  );

  // With pause compiled out the detector still runs but can never move the FSM.
  assign pause_rise = pause_rise_raw & PAUSE_EN;

  // Threshold for the next level is a constant multiply, so no divider is built.
  always_comb begin
    score_u      = 32'(score);
    level_thresh = (32'(level_q) + 32'd1) * STEP_U;
    win_hit      = (score_u >= WIN_U);
    lose_hit     = (lives_q == '0) || (time_q == '0);
  end

  always_comb begin
    state_d    = state_q;
    new_mole_d = 1'b0;
    lives_d    = lives_q;
    level_d    = level_q;
    time_d     = time_q;

    case (state_q)
      SETUP: begin
        lives_d = LIVES_INIT;
        level_d = '0;
        time_d  = TIME_INIT;
        if (play_rise) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (countdown_complete) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (mole_missed && (lives_q != '0)) begin
          lives_d = lives_q - 1'b1;
        end
        if (ms_tick && (time_q != '0)) begin
          time_d = time_q - 1'b1;
        end
        if ((level_q != LEVEL_MAX) && (score_u >= level_thresh)) begin
          level_d = level_q + 1'b1;
        end

        if (win_hit) begin
          state_d = WIN;
        end else if (lose_hit) begin
          state_d = GAME_OVER;
        end else if (pause_rise) begin
          state_d = PAUSE;
        end

        // A spawn request must not land in the first PAUSE cycle.
        new_mole_d = mole_complete && (state_d != PAUSE);
      end

      PAUSE: begin
        if (pause_rise) begin
          state_d = PLAY;
        end
      end

      GAME_OVER, WIN: begin
        if (play_rise) begin
          state_d = SETUP;
        end
      end

      default: begin
        state_d = SETUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SETUP;
      new_mole_q <= 1'b0;
      lives_q    <= LIVES_INIT;
      level_q    <= '0;
      time_q     <= TIME_INIT;
    end else begin
      state_q    <= state_d;
      new_mole_q <= new_mole_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      time_q     <= time_d;
    end
  end

  always_comb begin
    timer_reset   = (state_q == SETUP);
    wait_flag     = (state_q == WAIT);
    play_flag     = (state_q == PLAY);
    pause_flag    = PAUSE_EN && (state_q == PAUSE);
    gameover_flag = (state_q == GAME_OVER);
    win_flag      = (state_q == WIN);
    new_mole      = new_mole_q;
    lives         = lives_q;
    level         = level_q;
    time_left_ms  = time_q;
  end

endmodule

// File: tb/tb_game_control_fsm.sv
// Directed bench for game_control_fsm with a 5 ms round; pause checks follow GAME_PAUSE_EN.
module tb_game_control_fsm;

  logic        clk;
  logic        reset;
  logic        play;
  logic        pause;
  logic        countdown_complete;
  logic        mole_complete;
  logic        mole_missed;
  logic        ms_tick;
  logic [11:0] score;
  logic        timer_reset;
  logic        wait_flag;
  logic        play_flag;
  logic        pause_flag;
  logic        gameover_flag;
  logic        win_flag;
  logic        new_mole;
  logic [1:0]  lives;
  logic [1:0]  level;
  logic [15:0] time_left_ms;

  int total;
  int bad;

  // {timer_reset, wait, play, pause, gameover, win}
  logic [5:0] st;
  assign st = {timer_reset, wait_flag, play_flag, pause_flag, gameover_flag, win_flag};

  localparam logic [5:0] ST_SETUP = 6'b100000;
  localparam logic [5:0] ST_WAIT  = 6'b010000;
  localparam logic [5:0] ST_PLAY  = 6'b001000;
  localparam logic [5:0] ST_PAUSE = 6'b000100;
  localparam logic [5:0] ST_OVER  = 6'b000010;
  localparam logic [5:0] ST_WIN   = 6'b000001;

  game_control_fsm #(.ROUND_MS(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .play               (play),
    .pause              (pause),
    .countdown_complete (countdown_complete),
    .mole_complete      (mole_complete),
    .mole_missed        (mole_missed),
    .ms_tick            (ms_tick),
    .score              (score),
    .timer_reset        (timer_reset),
    .wait_flag          (wait_flag),
    .play_flag          (play_flag),
    .pause_flag         (pause_flag),
    .gameover_flag      (gameover_flag),
    .win_flag           (win_flag),
    .new_mole           (new_mole),
    .lives              (lives),
    .level              (level),
    .time_left_ms       (time_left_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_game();
    reset = 1'b1; score = '0; play = 1'b0; pause = 1'b0;
    mole_complete = 1'b0; mole_missed = 1'b0; ms_tick = 1'b0; countdown_complete = 1'b0;
    cyc(1);
    reset = 1'b0; play = 1'b1;
    cyc(1);
    play = 1'b0; countdown_complete = 1'b1;
    cyc(1);
    countdown_complete = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    total++; if (st !== ST_SETUP) begin bad++; $display("FAIL rst_state: got=%b exp=%b", st, ST_SETUP); end
    total++; if (lives !== 2'd3) begin bad++; $display("FAIL rst_lives: got=%0d exp=3", lives); end
    total++; if (level !== 2'd0) begin bad++; $display("FAIL rst_level: got=%0d exp=0", level); end
    total++; if (time_left_ms !== 16'd5) begin bad++; $display("FAIL rst_time: got=%0d exp=5", time_left_ms); end
    total++; if (new_mole !== 1'b0) begin bad++; $display("FAIL rst_new_mole: got=%0d exp=0", new_mole); end
    cyc(1);
    total++; if (st !== ST_SETUP) begin bad++; $display("FAIL rst_hold: got=%b exp=%b", st, ST_SETUP); end
  endtask

  task automatic test_misses();
    reset = 1'b1; cyc(1); reset = 1'b0;
    play = 1'b1; cyc(1); play = 1'b0;
    total++; if (st !== ST_WAIT) begin bad++; $display("FAIL miss_wait: got=%b exp=%b", st, ST_WAIT); end
    cyc(1);
    total++; if (st !== ST_WAIT) begin bad++; $display("FAIL miss_wait_hold: got=%b exp=%b", st, ST_WAIT); end
    countdown_complete = 1'b1; cyc(1); countdown_complete = 1'b0;
    total++; if (st !== ST_PLAY) begin bad++; $display("FAIL miss_play: got=%b exp=%b", st, ST_PLAY); end
    mole_missed = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      total++; if (lives !== 2'(3 - i)) begin bad++; $display("FAIL miss_lives%0d: got=%0d exp=%0d", i, lives, 3 - i); end
    end
    total++; if (st !== ST_PLAY) begin bad++; $display("FAIL miss_still_play: got=%b exp=%b", st, ST_PLAY); end
    mole_missed = 1'b0;
    cyc(1);
    total++; if (st !== ST_OVER) begin bad++; $display("FAIL miss_over: got=%b exp=%b", st, ST_OVER); end
    mole_missed = 1'b1; cyc(1); mole_missed = 1'b0;
    total++; if (lives !== 2'd0) begin bad++; $display("FAIL miss_frozen: got=%0d exp=0", lives); end
  endtask

  task automatic test_level();
    start_game();
    score = 12'd260; cyc(2);
    total++; if (level !== 2'd1) begin bad++; $display("FAIL lvl_1: got=%0d exp=1", level); end
    score = 12'd520; cyc(2);
    total++; if (level !== 2'd2) begin bad++; $display("FAIL lvl_2: got=%0d exp=2", level); end
    total++; if (st !== ST_PLAY) begin bad++; $display("FAIL lvl_play: got=%b exp=%b", st, ST_PLAY); end
    score = 12'd1000; cyc(1);
    total++; if (st !== ST_WIN) begin bad++; $display("FAIL lvl_win: got=%b exp=%b", st, ST_WIN); end
    total++; if (gameover_flag !== 1'b0) begin bad++; $display("FAIL lvl_no_over: got=%0d exp=0", gameover_flag); end
    total++; if (level !== 2'd3) begin bad++; $display("FAIL lvl_3: got=%0d exp=3", level); end
    cyc(2);
    total++; if (level !== 2'd3) begin bad++; $display("FAIL lvl_sat: got=%0d exp=3", level); end
    play = 1'b1; cyc(1); play = 1'b0;
    total++; if (st !== ST_SETUP) begin bad++; $display("FAIL lvl_restart: got=%b exp=%b", st, ST_SETUP); end
    cyc(1);
    total++; if (level !== 2'd0) begin bad++; $display("FAIL lvl_reload: got=%0d exp=0", level); end
  endtask

  task automatic test_timer();
    start_game();
    total++; if (time_left_ms !== 16'd5) begin bad++; $display("FAIL tmr_start: got=%0d exp=5", time_left_ms); end
    cyc(1);
    total++; if (time_left_ms !== 16'd5) begin bad++; $display("FAIL tmr_no_tick: got=%0d exp=5", time_left_ms); end
    for (int i = 1; i <= 5; i++) begin
      ms_tick = 1'b1; cyc(1);
      total++; if (time_left_ms !== 16'(5 - i)) begin bad++; $display("FAIL tmr_tick%0d: got=%0d exp=%0d", i, time_left_ms, 5 - i); end
    end
    total++; if (st !== ST_PLAY) begin bad++; $display("FAIL tmr_play: got=%b exp=%b", st, ST_PLAY); end
    cyc(1);
    ms_tick = 1'b0;
    total++; if (time_left_ms !== 16'd0) begin bad++; $display("FAIL tmr_sat: got=%0d exp=0", time_left_ms); end
    total++; if (st !== ST_OVER) begin bad++; $display("FAIL tmr_over: got=%b exp=%b", st, ST_OVER); end
  endtask

  task automatic test_mole();
    start_game();
    mole_complete = 1'b1; cyc(1); mole_complete = 1'b0;
    total++; if (new_mole !== 1'b1) begin bad++; $display("FAIL mole_pulse: got=%0d exp=1", new_mole); end
    cyc(1);
    total++; if (new_mole !== 1'b0) begin bad++; $display("FAIL mole_one_cycle: got=%0d exp=0", new_mole); end
    mole_complete = 1'b1; mole_missed = 1'b1; cyc(1); mole_complete = 1'b0; mole_missed = 1'b0;
    total++; if (new_mole !== 1'b1) begin bad++; $display("FAIL mole_both_pulse: got=%0d exp=1", new_mole); end
    total++; if (lives !== 2'd2) begin bad++; $display("FAIL mole_both_life: got=%0d exp=2", lives); end
    mole_missed = 1'b1; cyc(1); mole_missed = 1'b0;
    total++; if (new_mole !== 1'b0) begin bad++; $display("FAIL mole_miss_only_pulse: got=%0d exp=0", new_mole); end
    total++; if (lives !== 2'd1) begin bad++; $display("FAIL mole_miss_only_life: got=%0d exp=1", lives); end
  endtask

  task automatic test_pause();
    start_game();
`ifdef GAME_PAUSE_EN
    pause = 1'b1; cyc(1); pause = 1'b0;
    total++; if (st !== ST_PAUSE) begin bad++; $display("FAIL pse_enter: got=%b exp=%b", st, ST_PAUSE); end
    ms_tick = 1'b1; mole_complete = 1'b1; cyc(1);
    total++; if (time_left_ms !== 16'd5) begin bad++; $display("FAIL pse_time: got=%0d exp=5", time_left_ms); end
    total++; if (new_mole !== 1'b0) begin bad++; $display("FAIL pse_mole: got=%0d exp=0", new_mole); end
    cyc(1);
    ms_tick = 1'b0; mole_complete = 1'b0;
    total++; if (new_mole !== 1'b0) begin bad++; $display("FAIL pse_mole2: got=%0d exp=0", new_mole); end
    total++; if (pause_flag !== 1'b1) begin bad++; $display("FAIL pse_hold: got=%0d exp=1", pause_flag); end
    pause = 1'b1; cyc(1); pause = 1'b0;
    total++; if (st !== ST_PLAY) begin bad++; $display("FAIL pse_resume: got=%b exp=%b", st, ST_PLAY); end
`else
    pause = 1'b1; ms_tick = 1'b1; cyc(1); pause = 1'b0; ms_tick = 1'b0;
    total++; if (st !== ST_PLAY) begin bad++; $display("FAIL pse_ignored: got=%b exp=%b", st, ST_PLAY); end
    total++; if (time_left_ms !== 16'd4) begin bad++; $display("FAIL pse_time_runs: got=%0d exp=4", time_left_ms); end
    cyc(1);
    total++; if (pause_flag !== 1'b0) begin bad++; $display("FAIL pse_flag_tied: got=%0d exp=0", pause_flag); end
`endif
  endtask

  task automatic test_priority_and_reset();
    start_game();
    mole_missed = 1'b1; cyc(3); mole_missed = 1'b0;
    total++; if (lives !== 2'd0) begin bad++; $display("FAIL pri_lives0: got=%0d exp=0", lives); end
    score = 12'd1000; cyc(1);
    total++; if (st !== ST_WIN) begin bad++; $display("FAIL pri_win: got=%b exp=%b", st, ST_WIN); end

    start_game();
    mole_missed = 1'b1; score = 12'd260; ms_tick = 1'b1; cyc(1);
    mole_missed = 1'b0; ms_tick = 1'b0;
    total++; if ({lives, level, time_left_ms} !== {2'd2, 2'd1, 16'd4}) begin bad++; $display("FAIL pri_pre_reset: got=%0d/%0d/%0d exp=2/1/4", lives, level, time_left_ms); end
    mole_complete = 1'b1; reset = 1'b1; cyc(1);
    mole_complete = 1'b0; reset = 1'b0;
    total++; if (st !== ST_SETUP) begin bad++; $display("FAIL pri_rst_state: got=%b exp=%b", st, ST_SETUP); end
    total++; if ({lives, level, time_left_ms} !== {2'd3, 2'd0, 16'd5}) begin bad++; $display("FAIL pri_rst_vals: got=%0d/%0d/%0d exp=3/0/5", lives, level, time_left_ms); end
    total++; if (new_mole !== 1'b0) begin bad++; $display("FAIL pri_rst_mole: got=%0d exp=0", new_mole); end
    cyc(1);
    total++; if (new_mole !== 1'b0) begin bad++; $display("FAIL pri_rst_mole2: got=%0d exp=0", new_mole); end
  endtask

  task automatic test_play_held();
    start_game();
    play = 1'b1;
    mole_missed = 1'b1; cyc(3); mole_missed = 1'b0;
    cyc(1);
    total++; if (st !== ST_OVER) begin bad++; $display("FAIL held_over: got=%b exp=%b", st, ST_OVER); end
    cyc(3);
    total++; if (st !== ST_OVER) begin bad++; $display("FAIL held_no_restart: got=%b exp=%b", st, ST_OVER); end
    play = 1'b0; cyc(1);
    total++; if (st !== ST_OVER) begin bad++; $display("FAIL held_release: got=%b exp=%b", st, ST_OVER); end
    play = 1'b1; cyc(1); play = 1'b0;
    total++; if (st !== ST_SETUP) begin bad++; $display("FAIL held_repress: got=%b exp=%b", st, ST_SETUP); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; play = 1'b0; pause = 1'b0; countdown_complete = 1'b0;
    mole_complete = 1'b0; mole_missed = 1'b0; ms_tick = 1'b0; score = '0;
    test_reset();
    test_misses();
    test_level();
    test_timer();
    test_mole();
    test_pause();
    test_priority_and_reset();
    test_play_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
